// File: rtl/unibus_master_arb_if.sv
// Requester and UNIBUS-side signal bundle for unibus_master_arb.
// The master modport is taken by the arbiter. The slave modport is taken by the requesters and bus slaves.
interface unibus_master_arb_if;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 16;

    logic [1:0]    req;
    logic [1:0]    we;
    logic [1:0]    bytem;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic          bus_init;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_d_out;
    logic [DW-1:0] bus_d_in;
    logic          bus_msyn;
    logic          bus_ssyn;
    logic          bus_c0;
    logic          bus_c1;

    modport master (
        input  req, we, bytem, addr0, addr1, wdata0, wdata1, bus_d_in, bus_ssyn,
        output ack, err, rdata, bus_init, bus_addr, bus_d_out, bus_msyn, bus_c0, bus_c1
    );

    modport slave (
        output req, we, bytem, addr0, addr1, wdata0, wdata1, bus_d_in, bus_ssyn,
        input  ack, err, rdata, bus_init, bus_addr, bus_d_out, bus_msyn, bus_c0, bus_c1
    );
endinterface

// File: rtl/unibus_master_arb.sv
// Two-port (0 = DMA, 1 = CPU) round-robin UNIBUS master that runs DATI/DATO/DATOB cycles.
// It uses the msyn/ssyn handshake and generates bus_init after reset.
// Optional feature macro UNIBUS_TIMEOUT_EN: when it is defined, a cycle aborts with err=1 if no ssyn
// arrives within TIMEOUT cycles. When it is undefined, MSYN waits indefinitely and err stays 0.
module unibus_master_arb #(
    parameter int unsigned DESKEW   = 2,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned INIT_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    unibus_master_arb_if.master bus
);
    localparam int unsigned AW      = 18;
    localparam int unsigned DW      = 16;
    localparam int unsigned MAX_A   = (DESKEW > INIT_LEN) ? DESKEW : INIT_LEN;
    localparam int unsigned CNT_MAX = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_MSYN  = 3'd3;
    localparam logic [2:0] S_END   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;
    logic             abort_q, abort_d;
    logic             init_q, init_d;
    logic             msyn_q, msyn_d;
    logic             c0_q, c0_d;
    logic             c1_q, c1_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       ack_q, ack_d;
    logic             err_q, err_d;
    logic             sel;
    logic             sel_we;
    logic             sel_bytem;

    assign bus.bus_init  = init_q;
    assign bus.bus_msyn  = msyn_q;
    assign bus.bus_c0    = c0_q;
    assign bus.bus_c1    = c1_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_d_out = dout_q;
    assign bus.rdata     = rdata_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;

    // State and registered outputs; reset clears msyn asynchronously and restarts INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            abort_q <= 1'b0;
            init_q  <= 1'b1;
            msyn_q  <= 1'b0;
            c0_q    <= 1'b0;
            c1_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            abort_q <= abort_d;
            init_q  <= init_d;
            msyn_q  <= msyn_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic; ack/err are single-cycle pulses
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        abort_d   = abort_q;
        init_d    = init_q;
        msyn_d    = msyn_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        ack_d     = 2'b00;
        err_d     = 1'b0;
        sel       = (bus.req == 2'b11) ? rr_q : bus.req[1];
        sel_we    = bus.we[sel];
        sel_bytem = bus.bytem[sel];

        case (state_q)
            S_INIT: begin
                if (cnt_q == CNT_W'(INIT_LEN - 1)) begin
                    init_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    gnt_d   = sel;
                    abort_d = 1'b0;
                    addr_d  = sel ? bus.addr1 : bus.addr0;
                    c1_d    = sel_we;
                    c0_d    = sel_we & sel_bytem;
                    dout_d  = sel_we ? (sel ? bus.wdata1 : bus.wdata0) : DW'(0);
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(DESKEW - 1)) begin
                    msyn_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_MSYN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MSYN: begin
                if (bus.bus_ssyn) begin
                    if (!c1_q) begin
                        rdata_d = bus.bus_d_in;
                    end
                    msyn_d  = 1'b0;
                    state_d = S_END;
                end
`ifdef UNIBUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    msyn_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = S_END;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_END: begin
                if (!bus.bus_ssyn) begin
                    ack_d   = gnt_q ? 2'b10 : 2'b01;
                    err_d   = abort_q;
                    abort_d = 1'b0;
                    addr_d  = '0;
                    dout_d  = '0;
                    c0_d    = 1'b0;
                    c1_d    = 1'b0;
                    rr_d    = ~gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
                init_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: doc/unibus_master_arb.md
# unibus_master_arb

Two-port bus master that arbitrates between requesters (port 0 = DMA, port 1 = CPU) and sequences PDP-11 style DATI/DATO/DATOB cycles on the shared bus using the msyn/ssyn handshake. It sits between the requesters and the bus slaves (main memory and I/O), and drives address, data, control and `bus_msyn`. It also generates `bus_init` after reset and, optionally, a bus-timeout error.

## Interface
Parameters:
- `DESKEW`, 2: cycles address/data/control are held stable before `bus_msyn` rises (≥1).
- `TIMEOUT`, 64: cycles of `bus_msyn` without `bus_ssyn` before the cycle aborts.
- `INIT_LEN`, 8: cycles `bus_init` stays high after reset deasserts.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req[1:0]`  in  2  request per port; held until that port's `ack`.
- `we[1:0]`  in  2  1 = write (DATO/DATOB), 0 = read (DATI).
- `bytem[1:0]`  in  2  byte write; ignored on reads.
- `addr0`, `addr1`  in  18  byte address per port.
- `wdata0`, `wdata1`  in  16  write data per port.
- `ack[1:0]`  out  2  one-cycle completion pulse per port.
- `err`  out  1  qualifies `ack`: 1 = timeout abort.
- `rdata`  out  16  read data; valid with `ack` and held until the next read capture.
- `bus_init`  out  1  bus initialize.
- `bus_addr`  out  18  bus address.
- `bus_d_out`  out  16  data driven to the bus; 0 unless the active cycle is a write.
- `bus_d_in`  in  16  data from slaves (OR of all slave outputs).
- `bus_msyn`  out  1  master sync.
- `bus_ssyn`  in  1  slave sync.
- `bus_c0`, `bus_c1`  out  1  `c1` = write, `c0` = byte (DATOB when both set).

## Operation
States are INIT, IDLE, SETUP, MSYN, END.
- **Reset:** state INIT, `bus_init`=1, all other outputs 0, `rdata`=0, round-robin pointer = port 0.
- **INIT:** counts `INIT_LEN` cycles, then drops `bus_init` and moves to IDLE. Requests are ignored in INIT.
- **IDLE:**
  - If any `req` is set, grant one port:
    - Only one port requesting: grant that port.
    - Both requesting: grant the port not granted last (round-robin).
  - On grant, latch that port's addr/we/bytem/wdata into internal registers and drive the bus from them.
  - Move to SETUP.
- **SETUP:** hold the bus for `DESKEW` cycles, then move to MSYN.
- **MSYN:** `bus_msyn`=1, timeout counter running.
  - When `bus_ssyn`=1: capture `bus_d_in` into `rdata` (reads only), drop `bus_msyn`, move to END.
  - When the counter reaches `TIMEOUT`: drop `bus_msyn`, set the internal abort flag, move to END.
- **END:** address, data and control stay driven until `bus_ssyn`=0. Then:
  - pulse `ack[g]`, with `err` = abort flag;
  - clear the bus outputs;
  - update the round-robin pointer;
  - return to IDLE.
- Bus-out rules:
  - `bus_c1` = latched `we`.
  - `bus_c0` = latched `we & bytem`.
  - `bus_d_out` = latched `wdata` only when `we`=1.
  - `bus_addr` is passed through unmodified, including bit 0.
- A `req` drop mid-cycle is ignored: the cycle completes and `ack` still pulses.
- `reset` asserted mid-cycle forces INIT immediately; `bus_msyn` falls asynchronously, and no `ack` is issued.

## Timing
- Grant: the cycle after `req` is seen in IDLE, the bus outputs are valid.
- `bus_msyn` rises exactly `DESKEW` cycles after the bus outputs become valid.
- `rdata` updates on the clock edge where `bus_ssyn`=1 is sampled in MSYN.
- `bus_msyn` falls one cycle after `bus_ssyn` is sampled high.
- `ack` pulses one cycle after `bus_ssyn` is sampled low in END.
- Minimum request-to-request spacing: after `ack`, the block is in IDLE and a new grant occurs the next cycle.
- Against main memory (16-cycle ssyn delay on both edges), `ack` arrives about `DESKEW`+34 cycles after grant.
- Timeout: `bus_msyn` is high for exactly `TIMEOUT` cycles, then falls.

## Configuration
Macro `UNIBUS_TIMEOUT_EN`:
- **Defined:** the timeout counter and the `err` path are built as described above.
- **Undefined:** MSYN waits indefinitely for `bus_ssyn`, and `err` is tied to 0.

## Test plan
- **Reset and init:** assert `reset` for 3 cycles, then release → `bus_init`=1 for exactly 8 cycles; `bus_msyn`, `ack` and `rdata` stay 0; a `req` raised during INIT is granted only after `bus_init` falls.
- **Word write then read:** port 1 writes 0o123456 to 0o001000, then reads 0o001000 → the write cycle shows `bus_c1`=1, `bus_c0`=0; after the read, `ack[1]` pulses with `rdata`=0o123456 and `err`=0.
- **Byte write:** port 0 writes 0o177 with `bytem`=1 to 0o001001 over a word holding 0o123456 → a read returns 0o077456, and `bus_c0`=`bus_c1`=1 during the write cycle.
- **Round-robin:** both ports raise `req` continuously from reset → grant order is 0,1,0,1; no port is granted twice in a row.
- **Timeout:** port 0 reads 0o760000 with no slave responding, `UNIBUS_TIMEOUT_EN` defined → `bus_msyn` is high for exactly 64 cycles, then `ack[0]`=1, `err`=1, `rdata` unchanged.
- **Reset mid-cycle:** assert `reset` while in MSYN → `bus_msyn`=0 immediately, no `ack` is issued, and the INIT sequence repeats.
